// File: rtl/minmax_stream.sv
// Purpose : running min/max over a valid/ready sample stream, one result per frame.
// Latency : m_valid rises the cycle after the closing beat is accepted.
// Backpr. : s_ready drops while a result is pending; the result holds until m_ready.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready        input sample handshake; s_data sample, s_last frame end
//   us_sel, min_max_sel    signed/unsigned and min/max select, latched on first beat
//   m_valid/m_ready        result handshake
//   m_result, m_index      extreme value and 0-based index of its first occurrence
//   m_count, m_trunc       samples in frame, frame closed by the NI limit
module minmax_stream #(
    parameter int W      = 5,
    parameter int NI     = 7,
    parameter int IDXW   = (NI > 1) ? $clog2(NI) : 1,
    parameter int MM_CFG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    input  logic            s_last,
    input  logic            us_sel,
    input  logic            min_max_sel,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_result,
    output logic [IDXW-1:0] m_index,
    output logic [IDXW:0]   m_count,
    output logic            m_trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDXW:0] NI_CNT = (IDXW + 1)'(NI);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    acc_q;
    logic [IDXW-1:0] acc_idx_q;
    logic [IDXW:0]   cnt_q;
    logic            sgn_q;
    logic            mx_q;
    logic            trunc_q;

    logic beat;
    logic mm_eff;
    logic cnt_hits_ni;
    logic end_idle;
    logic end_accum;

    // Strict comparison only, so a tie never displaces the earlier index.
    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn, input logic mx);
        logic lt;
        logic gt;
        if (sgn) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return mx ? gt : lt;
    endfunction

    // Ready is a pure state decode, gated low while reset is held.
    assign s_ready     = !rst && (state != DONE);
    assign beat        = s_valid && s_ready;
    assign mm_eff      = (MM_CFG == 2) ? 1'b1 : (MM_CFG == 1) ? 1'b0 : min_max_sel;
    assign cnt_hits_ni = ((cnt_q + 1'b1) == NI_CNT);
    assign end_idle    = s_last || (NI == 1);
    assign end_accum   = s_last || cnt_hits_ni;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat) begin
                    state_nxt = end_idle ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && end_accum) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_idx_q <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            mx_q      <= 1'b0;
            trunc_q   <= 1'b0;
        end else if (beat) begin
            if (state == IDLE) begin
                acc_q     <= s_data;
                acc_idx_q <= '0;
                cnt_q     <= (IDXW + 1)'(1);
                sgn_q     <= us_sel;
                mx_q      <= mm_eff;
                trunc_q   <= (NI == 1) && !s_last;
            end else begin
                if (better(s_data, acc_q, sgn_q, mx_q)) begin
                    acc_q     <= s_data;
                    acc_idx_q <= cnt_q[IDXW-1:0];
                end
                cnt_q   <= cnt_q + 1'b1;
                trunc_q <= cnt_hits_ni && !s_last;
            end
        end
    end

    // Accumulator registers feed the result directly; they are frozen in DONE.
    assign m_valid  = (state == DONE);
    assign m_result = acc_q;
    assign m_index  = acc_idx_q;
    assign m_count  = cnt_q;
    assign m_trunc  = trunc_q;

endmodule

// File: tb/tb_minmax_stream.sv
module tb_minmax_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [4:0] s_data;
    logic       s_last;
    logic       us_sel;
    logic       min_max_sel;
    logic       m_ready;

    logic       s_ready,  s_ready2;
    logic       m_valid,  m_valid2;
    logic [4:0] m_result, m_result2;
    logic [2:0] m_index,  m_index2;
    logic [3:0] m_count,  m_count2;
    logic       m_trunc,  m_trunc2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    minmax_stream #(.W(5), .NI(7), .MM_CFG(0)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .us_sel(us_sel), .min_max_sel(min_max_sel),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result), .m_index(m_index), .m_count(m_count), .m_trunc(m_trunc)
    );

    // Forced-max variant sharing the stimulus; it stays in lockstep with dut.
    minmax_stream #(.W(5), .NI(7), .MM_CFG(2)) dut2 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
        .us_sel(us_sel), .min_max_sel(min_max_sel),
        .m_valid(m_valid2), .m_ready(m_ready),
        .m_result(m_result2), .m_index(m_index2), .m_count(m_count2), .m_trunc(m_trunc2)
    );

    // Present one beat, let one rising edge pass, sample point is 1 after that edge.
    task automatic beat(input logic [4:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_result();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0;
        us_sel = 0; min_max_sel = 0; m_ready = 0;
        #2;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready got %0h exp 0", s_ready); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %0h exp 0", m_valid); end
        vectors++; if ({m_result, m_index, m_count, m_trunc} !== 13'h0) begin miscompares++;
            $display("FAIL rst_outputs got %0h/%0h/%0h/%0h exp 0", m_result, m_index, m_count, m_trunc); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL idle_s_ready got %0h exp 1", s_ready); end
    endtask

    task automatic test_unsigned_min();
        us_sel = 0; min_max_sel = 0;
        beat(5'd7, 0); beat(5'd3, 0); beat(5'd9, 0); beat(5'd3, 0);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL umin_early_valid got %0h exp 0", m_valid); end
        beat(5'd12, 1);
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL umin_valid got %0h exp 1", m_valid); end
        vectors++; if (m_result !== 5'd3) begin miscompares++; $display("FAIL umin_result got %0d exp 3", m_result); end
        vectors++; if (m_index !== 3'd1) begin miscompares++; $display("FAIL umin_index got %0d exp 1", m_index); end
        vectors++; if (m_count !== 4'd5) begin miscompares++; $display("FAIL umin_count got %0d exp 5", m_count); end
        vectors++; if (m_trunc !== 1'b0) begin miscompares++; $display("FAIL umin_trunc got %0d exp 0", m_trunc); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL umin_done_ready got %0d exp 0", s_ready); end
        vectors++; if ({m_result2, m_index2} !== {5'd12, 3'd4}) begin miscompares++;
            $display("FAIL umin_forced_max got %0d/%0d exp 12/4", m_result2, m_index2); end
        release_result();
    endtask

    task automatic test_signedness();
        us_sel = 1; min_max_sel = 1;
        beat(5'h1F, 0); beat(5'h0F, 0); beat(5'h10, 1);
        vectors++; if (m_result !== 5'h0F) begin miscompares++; $display("FAIL smax_result got %0h exp 0f", m_result); end
        vectors++; if (m_index !== 3'd1) begin miscompares++; $display("FAIL smax_index got %0d exp 1", m_index); end
        vectors++; if (m_count !== 4'd3) begin miscompares++; $display("FAIL smax_count got %0d exp 3", m_count); end
        release_result();
        us_sel = 0;
        beat(5'h1F, 0); beat(5'h0F, 0); beat(5'h10, 1);
        vectors++; if (m_result !== 5'h1F) begin miscompares++; $display("FAIL umax_result got %0h exp 1f", m_result); end
        vectors++; if (m_index !== 3'd0) begin miscompares++; $display("FAIL umax_index got %0d exp 0", m_index); end
        release_result();
        // Signed min: -16 is smallest, at index 2.
        us_sel = 1; min_max_sel = 0;
        beat(5'h1F, 0); beat(5'h0F, 0); beat(5'h10, 1);
        vectors++; if ({m_result, m_index} !== {5'h10, 3'd2}) begin miscompares++;
            $display("FAIL smin got %0h/%0d exp 10/2", m_result, m_index); end
        release_result();
    endtask

    task automatic test_truncation();
        us_sel = 0; min_max_sel = 0;
        beat(5'd5, 0); beat(5'd4, 0); beat(5'd3, 0); beat(5'd2, 0);
        beat(5'd1, 0); beat(5'd0, 0); beat(5'd6, 0);
        // 8th beat offered while DONE: must stall.
        s_valid = 1; s_data = 5'd9; s_last = 1; m_ready = 1;
        #1;
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL trunc_valid got %0d exp 1", m_valid); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL trunc_stall got %0d exp 0", s_ready); end
        vectors++; if ({m_result, m_index} !== {5'd0, 3'd5}) begin miscompares++;
            $display("FAIL trunc_min got %0d/%0d exp 0/5", m_result, m_index); end
        vectors++; if ({m_count, m_trunc} !== {4'd7, 1'b1}) begin miscompares++;
            $display("FAIL trunc_flag got %0d/%0d exp 7/1", m_count, m_trunc); end
        @(posedge clk); #1;
        m_ready = 0;
        vectors++; if ({m_valid, s_ready} !== 2'b01) begin miscompares++;
            $display("FAIL trunc_release got valid %0d ready %0d exp 0/1", m_valid, s_ready); end
        @(posedge clk); #1;
        s_valid = 0; s_last = 0;
        vectors++; if ({m_valid, m_result, m_index, m_count, m_trunc} !== {1'b1, 5'd9, 3'd0, 4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL carry_beat got v%0d r%0d i%0d c%0d t%0d exp v1 r9 i0 c1 t0",
                     m_valid, m_result, m_index, m_count, m_trunc); end
        release_result();
        // s_last on beat NI closes normally: no truncation flag.
        for (int i = 0; i < 6; i++) beat(5'(10 + i), 0);
        beat(5'd20, 1);
        vectors++; if ({m_count, m_trunc, m_result} !== {4'd7, 1'b0, 5'd10}) begin miscompares++;
            $display("FAIL last_at_ni got c%0d t%0d r%0d exp c7 t0 r10", m_count, m_trunc, m_result); end
        release_result();
    endtask

    task automatic test_hold();
        us_sel = 0; min_max_sel = 0;
        beat(5'd4, 0); beat(5'd6, 1);
        s_valid = 1; s_data = 5'd0; s_last = 1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({m_valid, s_ready, m_result, m_index, m_count} !== {1'b1, 1'b0, 5'd4, 3'd0, 4'd2}) begin
                miscompares++;
                $display("FAIL hold_%0d got v%0d s%0d r%0d i%0d c%0d exp v1 s0 r4 i0 c2",
                         i, m_valid, s_ready, m_result, m_index, m_count); end
            @(posedge clk); #1;
        end
        s_valid = 0; s_last = 0;
        release_result();
        vectors++; if ({m_valid, s_ready} !== 2'b01) begin miscompares++;
            $display("FAIL hold_release got valid %0d ready %0d exp 0/1", m_valid, s_ready); end
    endtask

    task automatic test_mm_cfg_and_sel();
        us_sel = 0; min_max_sel = 0;
        beat(5'd2, 0); beat(5'd8, 0); beat(5'd8, 1);
        vectors++; if ({m_result2, m_index2} !== {5'd8, 3'd1}) begin miscompares++;
            $display("FAIL cfg2_max got %0d/%0d exp 8/1", m_result2, m_index2); end
        vectors++; if ({m_result, m_index} !== {5'd2, 3'd0}) begin miscompares++;
            $display("FAIL cfg0_min got %0d/%0d exp 2/0", m_result, m_index); end
        release_result();
        // Select toggled after first beat, with idle gaps mid-frame.
        beat(5'd5, 0);
        min_max_sel = 1; us_sel = 1;
        beat(5'd1, 0);
        @(posedge clk); @(posedge clk); #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid got %0d exp 0", m_valid); end
        beat(5'd9, 0); beat(5'd3, 1);
        vectors++; if ({m_result, m_index, m_count} !== {5'd1, 3'd1, 4'd4}) begin miscompares++;
            $display("FAIL sel_latched got %0d/%0d/%0d exp 1/1/4", m_result, m_index, m_count); end
        release_result();
        min_max_sel = 0; us_sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        beat(5'd6, 0); beat(5'd2, 0);
        s_valid = 1; s_data = 5'd1; s_last = 0;
        #2 rst = 1;
        #1;
        vectors++; if ({m_valid, s_ready} !== 2'b00) begin miscompares++;
            $display("FAIL midrst_handshake got v%0d s%0d exp 0/0", m_valid, s_ready); end
        vectors++; if ({m_result, m_index, m_count, m_trunc} !== 13'h0) begin miscompares++;
            $display("FAIL midrst_outputs got %0d/%0d/%0d/%0d exp 0", m_result, m_index, m_count, m_trunc); end
        s_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        beat(5'd11, 1);
        vectors++; if ({m_valid, m_result, m_index, m_count, m_trunc} !== {1'b1, 5'd11, 3'd0, 4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_beat got v%0d r%0d i%0d c%0d t%0d exp v1 r11 i0 c1 t0",
                     m_valid, m_result, m_index, m_count, m_trunc); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_unsigned_min();
        test_signedness();
        test_truncation();
        test_hold();
        test_mm_cfg_and_sel();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
